// File: rtl/scan_display_ctrl.sv
// Multiplexed 7-segment scan driver: per-digit divider, frame latch, leading-zero blanking, error pattern.
// Optional error blink is built only when SCAN_BLINK_EN is defined.
module scan_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] DataIn,
  input  logic                    ErrorFlag,
  output logic [NUM_DIGITS-1:0]   DIG,
  output logic [6:0]              codeout,
  output logic                    frame_tick
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_E    = 7'b1001111;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
  logic                    err_q, err_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic [6:0]              seg_q, seg_d;
  logic                    tick_q, tick_d;

  logic                    scan_tick;
  logic [4*NUM_DIGITS-1:0] src_frame;
  logic                    src_err;
  logic [3:0]              nib;
  logic                    all_zero;
  logic                    blank;

  always_comb begin
    scan_tick = (div_cnt_q == DIV_LAST);
    div_cnt_d = scan_tick ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    frame_d   = frame_q;
    err_d     = err_q;
    dig_d     = dig_q;
    seg_d     = seg_q;
    tick_d    = 1'b0;
    src_frame = frame_q;
    src_err   = err_q;
    nib       = '0;
    all_zero  = 1'b1;
    blank     = 1'b0;

    if (scan_tick) begin
      // On a wrap, digit 0 is decoded from the value being latched this edge.
      if (idx_q == IDX_LAST) begin
        idx_d     = '0;
        frame_d   = DataIn;
        err_d     = ErrorFlag;
        tick_d    = 1'b1;
        src_frame = DataIn;
        src_err   = ErrorFlag;
      end else begin
        idx_d = idx_q + 1'b1;
      end

      // Walk from the top digit down so all_zero covers nibbles i..NUM_DIGITS-1.
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        all_zero = all_zero && (src_frame[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
        if (IDX_W'(NUM_DIGITS-1-k) == idx_d) begin
          nib   = src_frame[4*(NUM_DIGITS-1-k) +: 4];
          blank = all_zero && (k != NUM_DIGITS-1);
        end
      end

      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        dig_d[i] = (IDX_W'(i) != idx_d);
      end

      if (src_err) begin
        seg_d = (idx_d == '0) ? SEG_E : SEG_DASH;
      end else if (blank) begin
        seg_d = '0;
      end else begin
        seg_d = glyph(nib);
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= IDX_LAST;
      frame_q   <= '0;
      err_q     <= 1'b0;
      dig_q     <= '1;
      seg_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      dig_q     <= dig_d;
      seg_q     <= seg_d;
      tick_q    <= tick_d;
    end
  end

  assign frame_tick = tick_q;

`ifdef SCAN_BLINK_EN
  localparam int HALF  = (CLK_HZ / BLINK_HZ / 2 > 1) ? CLK_HZ / BLINK_HZ / 2 : 1;
  localparam int BLK_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(HALF - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    if (!err_q) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  // Off-phase only masks the pins; the scan keeps running underneath.
  assign DIG     = (err_q && !blink_ph_q) ? '1 : dig_q;
  assign codeout = (err_q && !blink_ph_q) ? '0 : seg_q;
`else
  assign DIG     = dig_q;
  assign codeout = seg_q;
`endif

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl with DIV=10 (CLK_HZ=100, SCAN_HZ=10), default build.
module tb_scan_display_ctrl;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic [15:0] DataIn;
  logic        ErrorFlag;
  logic [3:0]  DIG;
  logic [6:0]  codeout;
  logic        frame_tick;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [3:0]  prev_dig;
  logic [6:0]  prev_seg;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] G6 = 7'b1011111;
  localparam logic [6:0] G7 = 7'b1110000;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] GE = 7'b1001111;
  localparam logic [6:0] GD = 7'b0000001;
  localparam logic [6:0] BL = 7'b0000000;

  scan_display_ctrl #(
    .NUM_DIGITS(4),
    .CLK_HZ    (100),
    .SCAN_HZ   (10),
    .BLINK_HZ  (1)
  ) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .DataIn    (DataIn),
    .ErrorFlag (ErrorFlag),
    .DIG       (DIG),
    .codeout   (codeout),
    .frame_tick(frame_tick)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Outputs must hold through the 9 edges before a tick, then change on the 10th.
  task automatic scan_step(input string tag, input logic [3:0] exp_dig,
                           input logic [6:0] exp_seg, input logic exp_ft);
    repeat (9) @(posedge clk_50M);
    #1;
    check({tag, " hold DIG"}, {28'd0, DIG}, {28'd0, prev_dig});
    check({tag, " hold seg"}, {25'd0, codeout}, {25'd0, prev_seg});
    check({tag, " hold tick"}, {31'd0, frame_tick}, 32'd0);
    @(posedge clk_50M);
    #1;
    check({tag, " DIG"}, {28'd0, DIG}, {28'd0, exp_dig});
    check({tag, " seg"}, {25'd0, codeout}, {25'd0, exp_seg});
    check({tag, " tick"}, {31'd0, frame_tick}, {31'd0, exp_ft});
    prev_dig = exp_dig;
    prev_seg = exp_seg;
  endtask

  initial begin
    rst_n     = 1'b0;
    DataIn    = 16'h1234;
    ErrorFlag = 1'b0;
    repeat (3) @(posedge clk_50M);
    #1;
    check("reset DIG", {28'd0, DIG}, 32'hF);
    check("reset seg", {25'd0, codeout}, 32'd0);
    check("reset tick", {31'd0, frame_tick}, 32'd0);
    rst_n    = 1'b1;
    prev_dig = 4'b1111;
    prev_seg = BL;

    // T1/T2: first frame and scan order
    scan_step("T1 d0", 4'b1110, G4, 1'b1);
    scan_step("T2 d1", 4'b1101, G3, 1'b0);
    scan_step("T2 d2", 4'b1011, G2, 1'b0);
    scan_step("T2 d3", 4'b0111, G1, 1'b0);
    scan_step("T2 wrap", 4'b1110, G4, 1'b1);
    DataIn = 16'h0070;
    scan_step("T2 d1b", 4'b1101, G3, 1'b0);
    scan_step("T2 d2b", 4'b1011, G2, 1'b0);
    scan_step("T2 d3b", 4'b0111, G1, 1'b0);

    // T3: leading zeros
    scan_step("T3 d0", 4'b1110, G0, 1'b1);
    scan_step("T3 d1", 4'b1101, G7, 1'b0);
    scan_step("T3 d2", 4'b1011, BL, 1'b0);
    scan_step("T3 d3", 4'b0111, BL, 1'b0);
    DataIn = 16'h0000;
    scan_step("T3z d0", 4'b1110, G0, 1'b1);
    scan_step("T3z d1", 4'b1101, BL, 1'b0);
    scan_step("T3z d2", 4'b1011, BL, 1'b0);
    scan_step("T3z d3", 4'b0111, BL, 1'b0);
    DataIn = 16'h1111;

    // T4: tearing and invalid BCD
    scan_step("T4 d0", 4'b1110, G1, 1'b1);
    scan_step("T4 d1", 4'b1101, G1, 1'b0);
    DataIn = 16'h22A2;
    scan_step("T4 d2", 4'b1011, G1, 1'b0);
    scan_step("T4 d3", 4'b0111, G1, 1'b0);
    scan_step("T4n d0", 4'b1110, G2, 1'b1);
    scan_step("T4n d1", 4'b1101, GD, 1'b0);
    scan_step("T4n d2", 4'b1011, G2, 1'b0);
    scan_step("T4n d3", 4'b0111, G2, 1'b0);
    DataIn = 16'h5678;

    // T5: error override latched only at the wrap
    scan_step("T5 d0", 4'b1110, G8, 1'b1);
    ErrorFlag = 1'b1;
    scan_step("T5 d1", 4'b1101, G7, 1'b0);
    scan_step("T5 d2", 4'b1011, G6, 1'b0);
    scan_step("T5 d3", 4'b0111, G5, 1'b0);
    scan_step("T5e d0", 4'b1110, GE, 1'b1);
    ErrorFlag = 1'b0;
    scan_step("T5e d1", 4'b1101, GD, 1'b0);
    scan_step("T5e d2", 4'b1011, GD, 1'b0);
    scan_step("T5e d3", 4'b0111, GD, 1'b0);
    scan_step("T5r d0", 4'b1110, G8, 1'b1);
    scan_step("T5r d1", 4'b1101, G7, 1'b0);
    scan_step("T5r d2", 4'b1011, G6, 1'b0);

    // T6: one-cycle reset while on digit 2
    rst_n = 1'b0;
    @(posedge clk_50M);
    #1;
    check("T6 rst DIG", {28'd0, DIG}, 32'hF);
    check("T6 rst seg", {25'd0, codeout}, 32'd0);
    check("T6 rst tick", {31'd0, frame_tick}, 32'd0);
    rst_n    = 1'b1;
    prev_dig = 4'b1111;
    prev_seg = BL;
    scan_step("T6 d0", 4'b1110, G8, 1'b1);
    scan_step("T6 d1", 4'b1101, G7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
